// File: rtl/stream_pkg.sv
// Shared stream-slice types. The state enum is common to the backward,
// forward and full register slices.
package stream_pkg;

    typedef enum logic [1:0] {
        RESET = 2'd0,
        EMPTY = 2'd1,
        FULL  = 2'd2
    } slice_state_t;

    // A backward slice only ever needs to absorb the one beat that was in
    // flight when downstream deasserted ready.
    localparam int unsigned SLICE_SKID_DEPTH = 1;

endpackage

// File: rtl/reg_slice_backward.sv
// Backward register slice: in_ready comes straight from a flop, so
// out_ready never reaches in_ready combinationally. Forward data/valid pass
// through with zero latency unless a beat is parked in the one-entry skid.
module reg_slice_backward
    import stream_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  skid_full
);

    slice_state_t          state_q, state_d;
    logic                  skid_valid_q, skid_valid_d;
    logic                  in_ready_q, in_ready_d;
    logic [DATA_WIDTH-1:0] skid_data_q;
    logic                  skid_load;

    // Next-state: park an accepted beat when downstream stalls, drain on ready.
    always_comb begin
        state_d   = state_q;
        skid_load = 1'b0;
        unique case (state_q)
            RESET: state_d = EMPTY;
            EMPTY: begin
                if (in_valid && in_ready_q && !out_ready) begin
                    state_d   = FULL;
                    skid_load = 1'b1;
                end
            end
            FULL: begin
                if (out_ready) begin
                    state_d = EMPTY;
                end
            end
            default: state_d = RESET;
        endcase
        // Registered ready is derived from where we are going, not from out_ready now.
        in_ready_d   = (state_d == EMPTY);
        skid_valid_d = (state_d == FULL);
    end

    // Control state with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q      <= RESET;
            skid_valid_q <= 1'b0;
            in_ready_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            skid_valid_q <= skid_valid_d;
            in_ready_q   <= in_ready_d;
        end
    end

    // Skid payload; no reset needed since skid_valid_q qualifies it.
    always_ff @(posedge clk) begin
        if (skid_load) begin
            skid_data_q <= in_data;
        end
    end

    // Output muxing: a parked beat always goes ahead of the live input.
    always_comb begin
        in_ready  = in_ready_q;
        out_valid = skid_valid_q | (in_valid & in_ready_q);
        out_data  = skid_valid_q ? skid_data_q : in_data;
        skid_full = (state_q == FULL);
    end

endmodule

// File: doc/reg_slice_backward.md
Name: reg_slice_backward

Overview:
- Register slice that registers only the backward (ready) path of a valid/ready stream.
- Forward data and valid pass combinationally, or come from a one-entry skid buffer.
- Pairs with the forward-only slice: the two together break every combinational path through a stream interface.
- Placed wherever a downstream ready feeds deep logic or crosses a floorplan region.

Parameters:
DATA_WIDTH, 64, width of the data field carried by the stream

Ports:
clk  input  1  stream clock; all interfaces synchronous to it
resetn  input  1  active-low reset, synchronous
in_data  input  DATA_WIDTH  upstream data
in_valid  input  1  upstream valid
in_ready  output  1  backpressure to upstream; driven directly from a flop
out_data  output  DATA_WIDTH  downstream data
out_valid  output  1  downstream valid
out_ready  input  1  downstream backpressure; never combinationally reaches in_ready
skid_full  output  1  status: skid buffer holds a beat (equal to state FULL)

Behaviour:
- Reset is synchronous and active-low. While resetn=0 at a clk edge:
  - state <= RESET, skid_valid <= 0, in_ready reg <= 0.
  - skid_data is not reset.
- Outputs while in RESET: in_ready=0, out_valid=0, skid_full=0; out_data = in_data, value don't-care.
- State machine, 3 states:
  - RESET: next edge with resetn=1 -> EMPTY; in_ready becomes 1 in that cycle.
  - EMPTY: skid empty, in_ready=1, out_valid=in_valid, out_data=in_data (zero-latency pass-through).
    - in_valid=1 & out_ready=1 -> beat passes straight through; stay EMPTY.
    - in_valid=1 & out_ready=0 -> beat accepted upstream (in_ready was 1), captured into skid_data; -> FULL.
    - in_valid=0 -> stay EMPTY.
  - FULL: in_ready=0, out_valid=1, out_data=skid_data; upstream data is ignored.
    - out_ready=1 -> skid drains; -> EMPTY; in_ready=1 next cycle.
    - out_ready=0 -> hold skid_data stable; stay FULL.
- in_ready is a flop computed from next-state: 1 iff next state is EMPTY.
- out_valid = skid_valid | (in_valid & in_ready), so no beat leaves unless upstream sees the transfer.
- Latency: 0 cycles in EMPTY, 1+ cycles when skidded. Throughput is 1 beat/cycle while out_ready stays high.
- Ordering:
  - Strict FIFO order; a skidded beat always exits before any later beat.
  - No beat is duplicated or dropped; each upstream handshake gives exactly one downstream handshake.
- AXI-stream rule: once out_valid=1 and out_ready=0, out_valid and out_data hold until the handshake.
  - In FULL this holds by construction.
  - In EMPTY it holds because the beat moves into skid on that same edge.
- Boundary: in FULL with out_ready=1 and in_valid=1 in the same cycle, the input is not accepted (in_ready=0). It is accepted the following cycle.
- Reset mid-operation: skidded beat discarded; out_valid drops in the reset cycle.

Decomposition:
- Shared package stream_pkg holds:
  - enum typedef slice_state_t {RESET, EMPTY, FULL}, reused by future full (forward+backward) slice.
  - localparam SLICE_SKID_DEPTH=1.
- No sub-module; a later full slice instantiates reg_slice_backward feeding the forward slice.

Test Plan:
- Reset: hold resetn=0 for 3 cycles with in_valid=1, in_data=0xAA -> in_ready=0, out_valid=0, skid_full=0 throughout; first cycle after release in_ready=1.
- Pass-through: out_ready=1, stream 0x01..0x10 back-to-back -> out_data equals in_data each cycle, 16 beats in 16 cycles, skid_full never 1.
- Single stall: send 0x05 with out_ready=0 -> next cycle skid_full=1, in_ready=0, out_data=0x05. Raise out_ready -> 0x05 consumed, then in_ready=1 the following cycle.
- Simultaneous drain and offer: FULL holding 0x07, in_valid=1, in_data=0x08, out_ready=1 -> 0x07 delivered, 0x08 not accepted that cycle; 0x08 delivered next cycle, no loss or duplication.
- Random backpressure: 1000 beats, incrementing data, out_ready random 50% -> scoreboard sees 0..999 in order. Assertions:
  - in_ready never depends combinationally on out_ready.
  - out_valid/out_data stable while stalled.
- Reset mid-stall: FULL holding 0x33, assert resetn=0 for 1 cycle -> out_valid=0, skid_full=0; 0x33 never appears after reset.
